// File: rtl/reg_mem_fifo_ctrl_pkg.sv
// Shared types and sizing for the reg_mem FIFO controller and its reg_mem instance.
package reg_mem_fifo_ctrl_pkg;

  localparam int unsigned DEF_DATA_WIDTH = 4;
  localparam int unsigned DEF_ADDR_BITS  = 3;

  // Arbitration priority between the read prefetch and the push write
  typedef enum logic {
    PRIO_RD = 1'b0,
    PRIO_WR = 1'b1
  } prio_e;

  // Number of words addressable by an ADDR_BITS-wide reg_mem port
  function automatic int unsigned depth_of(input int unsigned addr_bits);
    return 32'(1) << addr_bits;
  endfunction

endpackage

// File: rtl/reg_mem_fifo_ctrl_fifo_ptr.sv
// Wrapping ADDR_BITS-wide pointer with increment enable; used for wr_ptr and rd_ptr.
module fifo_ptr
  import reg_mem_fifo_ctrl_pkg::*;
#(
  parameter int unsigned ADDR_BITS = DEF_ADDR_BITS
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 i_inc,
  output logic [ADDR_BITS-1:0] o_ptr
);

  logic [ADDR_BITS-1:0] r_ptr;

  // Natural binary wrap from DEPTH-1 back to 0
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ptr <= '0;
    end else if (i_inc) begin
      r_ptr <= r_ptr + ADDR_BITS'(1);
    end
  end

  assign o_ptr = r_ptr;

endmodule

// File: rtl/reg_mem_fifo_ctrl.sv
// FIFO controller in front of a single-port reg_mem with a 1-entry prefetched output register.
// Define FIFO_BYPASS_EN to let a push into an empty FIFO load the output register directly.
module reg_mem_fifo_ctrl
  import reg_mem_fifo_ctrl_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int unsigned ADDR_BITS  = DEF_ADDR_BITS
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic [ADDR_BITS-1:0]  mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  output logic                  mem_wen,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  output logic [ADDR_BITS:0]    level,
  output logic                  full,
  output logic                  empty
);

  localparam int unsigned DEPTH = depth_of(ADDR_BITS);
  localparam int unsigned CW    = ADDR_BITS + 1;

  logic [CW-1:0]         r_mem_count;
  logic                  r_out_valid;
  logic [DATA_WIDTH-1:0] r_out_data;
  prio_e                 r_prio;

  logic [ADDR_BITS-1:0]  w_wr_ptr;
  logic [ADDR_BITS-1:0]  w_rd_ptr;
  logic                  w_full;
  logic                  w_rd_req;
  logic                  w_wr_req;
  logic                  w_in_ready;
  logic                  w_push;
  logic                  w_bypass;
  logic                  w_mem_wr;
  logic                  w_rd_grant;
  logic                  w_contested;

  assign w_full      = (r_mem_count == CW'(DEPTH));
  assign w_rd_req    = (r_mem_count != '0) && (!r_out_valid || out_ready);
  assign w_wr_req    = in_valid && !w_full;
  // Ready only blocks on a losing contest, so it never looks at in_valid
  assign w_in_ready  = !w_full && !(w_rd_req && (r_prio == PRIO_RD));
  assign w_push      = in_valid && w_in_ready;
  assign w_contested = w_rd_req && w_wr_req;
  assign w_rd_grant  = w_rd_req && !w_push;

`ifdef FIFO_BYPASS_EN
  assign w_bypass = w_push && (r_mem_count == '0) && (!r_out_valid || out_ready);
`else
  assign w_bypass = 1'b0;
`endif

  assign w_mem_wr = w_push && !w_bypass;

  fifo_ptr #(.ADDR_BITS(ADDR_BITS)) u_wr_ptr (
    .clk   (clk),
    .rst_n (rst_n),
    .i_inc (w_mem_wr),
    .o_ptr (w_wr_ptr)
  );

  fifo_ptr #(.ADDR_BITS(ADDR_BITS)) u_rd_ptr (
    .clk   (clk),
    .rst_n (rst_n),
    .i_inc (w_rd_grant),
    .o_ptr (w_rd_ptr)
  );

  // Occupancy, output register and arbitration priority
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mem_count <= '0;
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_prio      <= PRIO_RD;
    end else begin
      if (w_mem_wr && !w_rd_grant) begin
        r_mem_count <= r_mem_count + CW'(1);
      end else if (w_rd_grant && !w_mem_wr) begin
        r_mem_count <= r_mem_count - CW'(1);
      end
      if (w_rd_grant) begin
        r_out_data  <= mem_rdata;
        r_out_valid <= 1'b1;
      end else if (w_bypass) begin
        r_out_data  <= in_data;
        r_out_valid <= 1'b1;
      end else if (r_out_valid && out_ready) begin
        r_out_valid <= 1'b0;
      end
      if (w_contested) begin
        r_prio <= (r_prio == PRIO_RD) ? PRIO_WR : PRIO_RD;
      end
    end
  end

  assign in_ready  = w_in_ready;
  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign mem_addr  = w_mem_wr ? w_wr_ptr : w_rd_ptr;
  assign mem_wdata = in_data;
  assign mem_wen   = w_mem_wr;
  assign level     = CW'(r_mem_count + CW'(r_out_valid));
  assign full      = w_full;
  assign empty     = (level == '0);

endmodule

// File: tb/tb_reg_mem_fifo_ctrl.sv
// Directed bench for reg_mem_fifo_ctrl with a behavioural reg_mem; honours FIFO_BYPASS_EN.
module tb_reg_mem_fifo_ctrl;

  localparam int unsigned DW    = 4;
  localparam int unsigned AB    = 3;
  localparam int unsigned DEPTH = 8;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] in_data;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_data;
  logic [AB-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic          mem_wen;
  logic [DW-1:0] mem_rdata;
  logic [AB:0]   level;
  logic          full;
  logic          empty;

  int n_checks = 0;
  int n_fail   = 0;
  logic [DW-1:0] q[$];

  logic [DW-1:0] mem [DEPTH];

  always #5 clk = ~clk;

  always @(posedge clk) if (mem_wen) mem[mem_addr] <= mem_wdata;
  assign mem_rdata = mem[mem_addr];

  reg_mem_fifo_ctrl #(.DATA_WIDTH(DW), .ADDR_BITS(AB)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_wen   (mem_wen),
    .mem_rdata (mem_rdata),
    .level     (level),
    .full      (full),
    .empty     (empty)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    in_valid  = 1'b0;
    out_ready = 1'b0;
    in_data   = '0;
    rst_n     = 1'b0;
    q.delete();
    #13;
    rst_n = 1'b1;
    tick();
  endtask

  // Present d until accepted (bounded); in_valid is left high for back-to-back use
  task automatic push_word(input logic [DW-1:0] d, output bit ok);
    ok = 1'b0;
    in_valid = 1'b1;
    in_data  = d;
    for (int n = 0; n < 20; n++) begin
      #1;
      if (in_ready) begin
        q.push_back(d);
        tick();
        ok = 1'b1;
        break;
      end
      tick();
    end
  endtask

  // Take one word (bounded); out_ready is left high
  task automatic pop_word(output logic [DW-1:0] d, output int waits, output bit ok);
    ok = 1'b0;
    waits = 0;
    d = '0;
    out_ready = 1'b1;
    for (int n = 0; n < 20; n++) begin
      #1;
      if (out_valid) begin
        d = out_data;
        tick();
        ok = 1'b1;
        break;
      end
      waits++;
      tick();
    end
  endtask

  task automatic test_reset();
    do_reset();
    #1;
    n_checks++; if (level !== 4'd0) begin n_fail++; $display("FAIL reset_level got=%0d exp=0", level); end
    n_checks++; if (empty !== 1'b1) begin n_fail++; $display("FAIL reset_empty got=%0b exp=1", empty); end
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got=%0b exp=0", out_valid); end
    n_checks++; if (mem_wen !== 1'b0) begin n_fail++; $display("FAIL reset_mem_wen got=%0b exp=0", mem_wen); end
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready got=%0b exp=1", in_ready); end
    tick();
  endtask

  task automatic test_mid_reset();
    bit ok;
    do_reset();
    for (int i = 1; i <= 4; i++) push_word(DW'(i), ok);
    in_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    n_checks++; if (level !== 4'd0) begin n_fail++; $display("FAIL midrst_level got=%0d exp=0", level); end
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL midrst_out_valid got=%0b exp=0", out_valid); end
    n_checks++; if (out_data !== 4'd0) begin n_fail++; $display("FAIL midrst_out_data got=%0d exp=0", out_data); end
    n_checks++; if (empty !== 1'b1) begin n_fail++; $display("FAIL midrst_empty got=%0b exp=1", empty); end
    q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_fill();
    bit ok;
    do_reset();
    for (int i = 1; i <= 9; i++) begin
      push_word(DW'(i), ok);
      n_checks++; if (!ok) begin n_fail++; $display("FAIL fill_push_timeout got=%0d exp=accepted", i); end
    end
    in_valid = 1'b1;
    in_data  = 4'd15;
    #1;
    n_checks++; if (level !== 4'd9) begin n_fail++; $display("FAIL fill_level got=%0d exp=9", level); end
    n_checks++; if (full !== 1'b1) begin n_fail++; $display("FAIL fill_full got=%0b exp=1", full); end
    n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL fill_in_ready got=%0b exp=0", in_ready); end
    n_checks++; if (out_data !== 4'd1) begin n_fail++; $display("FAIL fill_out_data got=%0d exp=1", out_data); end
    tick();
    n_checks++; if (level !== 4'd9) begin n_fail++; $display("FAIL full_push_blocked got=%0d exp=9", level); end
    in_valid = 1'b0;
  endtask

  task automatic test_drain();
    logic [DW-1:0] d;
    int waits;
    bit ok;
    for (int i = 1; i <= 9; i++) begin
      pop_word(d, waits, ok);
      n_checks++;
      if (!ok || d !== DW'(i) || waits != 0) begin
        n_fail++;
        $display("FAIL drain_word got=%0d waits=%0d exp=%0d waits=0", d, waits, i);
      end
    end
    out_ready = 1'b0;
    #1;
    n_checks++; if (empty !== 1'b1 || level !== 4'd0) begin n_fail++; $display("FAIL drain_end got=empty%0b/level%0d exp=1/0", empty, level); end
    q.delete();
  endtask

  task automatic test_wrap();
    logic [DW-1:0] d;
    int waits;
    bit ok;
    do_reset();
    for (int i = 0; i < 6; i++) push_word(DW'(i + 10), ok);
    in_valid = 1'b0;
    for (int i = 0; i < 6; i++) begin
      pop_word(d, waits, ok);
      n_checks++; if (!ok || d !== DW'(i + 10)) begin n_fail++; $display("FAIL wrap_first got=%0d exp=%0d", d, i + 10); end
    end
    out_ready = 1'b0;
    for (int i = 1; i <= 8; i++) push_word(DW'(i), ok);
    in_valid = 1'b0;
    for (int i = 1; i <= 8; i++) begin
      pop_word(d, waits, ok);
      n_checks++; if (!ok || d !== DW'(i)) begin n_fail++; $display("FAIL wrap_second got=%0d exp=%0d", d, i); end
    end
    out_ready = 1'b0;
    q.delete();
  endtask

  task automatic test_contention();
    logic [DW-1:0] d;
    logic [DW-1:0] e;
    logic prev_wen;
    int waits;
    bit ok;
    do_reset();
    for (int i = 1; i <= 3; i++) push_word(DW'(i), ok);
    in_valid  = 1'b1;
    out_ready = 1'b1;
    in_data   = 4'd4;
    prev_wen  = 1'b0;
    for (int k = 0; k < 10; k++) begin
      #1;
      if (k > 0) begin
        n_checks++; if (mem_wen === prev_wen) begin n_fail++; $display("FAIL contend_alternate got=%0b exp=%0b", mem_wen, ~prev_wen); end
      end
      prev_wen = mem_wen;
      if (in_ready) q.push_back(in_data);
      if (out_valid) begin
        e = q.pop_front();
        n_checks++; if (out_data !== e) begin n_fail++; $display("FAIL contend_pop got=%0d exp=%0d", out_data, e); end
      end
      tick();
      in_data = in_data + 4'd1;
    end
    in_valid = 1'b0;
    while (q.size() > 0) begin
      e = q.pop_front();
      pop_word(d, waits, ok);
      n_checks++; if (!ok || d !== e) begin n_fail++; $display("FAIL contend_drain got=%0d exp=%0d", d, e); end
    end
    out_ready = 1'b0;
    #1;
    n_checks++; if (empty !== 1'b1) begin n_fail++; $display("FAIL contend_empty got=%0b exp=1", empty); end
  endtask

  task automatic test_bypass();
    logic exp_wen;
    logic exp_v1;
`ifdef FIFO_BYPASS_EN
    exp_wen = 1'b0;
    exp_v1  = 1'b1;
`else
    exp_wen = 1'b1;
    exp_v1  = 1'b0;
`endif
    do_reset();
    in_valid = 1'b1;
    in_data  = 4'd5;
    #1;
    n_checks++; if (mem_wen !== exp_wen) begin n_fail++; $display("FAIL bypass_wen got=%0b exp=%0b", mem_wen, exp_wen); end
    tick();
    in_valid = 1'b0;
    #1;
    n_checks++; if (out_valid !== exp_v1) begin n_fail++; $display("FAIL bypass_latency got=%0b exp=%0b", out_valid, exp_v1); end
    n_checks++; if (mem_wen !== 1'b0) begin n_fail++; $display("FAIL bypass_idle_wen got=%0b exp=0", mem_wen); end
    tick();
    n_checks++; if (out_valid !== 1'b1 || out_data !== 4'd5) begin n_fail++; $display("FAIL bypass_data got=%0b/%0d exp=1/5", out_valid, out_data); end
    n_checks++; if (level !== 4'd1) begin n_fail++; $display("FAIL bypass_level got=%0d exp=1", level); end
  endtask

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    in_data   = '0;
    test_reset();
    test_mid_reset();
    test_fill();
    test_drain();
    test_wrap();
    test_contention();
    test_bypass();
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/reg_mem_fifo_ctrl.md
Name: reg_mem_fifo_ctrl

Overview:
- Single-port FIFO controller sitting directly upstream of reg_mem. reg_mem is the storage array; this block owns its addr/data_in/wen port.
- Turns a valid/ready push stream into reg_mem writes. Prefetches reg_mem reads into a 1-entry output register that drives a valid/ready pop stream.
- reg_mem has one address port, so each cycle carries either one write or one read. The controller arbitrates between them.

Parameters:
- DATA_WIDTH, 4, word width; must match reg_mem.
- ADDR_BITS, 3, reg_mem address width. DEPTH = 2**ADDR_BITS is a derived localparam (8 words).

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  push request.
- in_ready  out  1  push accepted this cycle when in_valid && in_ready.
- in_data  in  DATA_WIDTH  push data.
- out_valid  out  1  out_data holds a valid word.
- out_ready  in  1  consumer takes the word when out_valid && out_ready.
- out_data  out  DATA_WIDTH  registered pop data.
- mem_addr  out  ADDR_BITS  to reg_mem addr.
- mem_wdata  out  DATA_WIDTH  to reg_mem data_in.
- mem_wen  out  1  to reg_mem wen.
- mem_rdata  in  DATA_WIDTH  from reg_mem data_out.
- level  out  ADDR_BITS+1  total words held: mem_count + out_valid, range 0..DEPTH+1.
- full  out  1  mem_count == DEPTH.
- empty  out  1  level == 0.

Behaviour:
- reg_mem port contract:
  - Write occurs at the rising edge when wen=1.
  - data_out = mem[addr] combinationally.
- State:
  - wr_ptr, rd_ptr: ADDR_BITS wide; wrap naturally DEPTH-1 -> 0.
  - mem_count: ADDR_BITS+1 wide.
  - out_valid, out_data.
  - prio: 0 = read priority, 1 = write priority.
- Reset values: pointers 0, mem_count 0, out_valid 0, out_data 0, prio 0, mem_wen 0. Memory contents are not cleared.
- Requests:
  - rd_req = (mem_count != 0) && (!out_valid || out_ready)
  - wr_req = in_valid && !full
- Arbitration:
  - If both requests are active, prio picks the winner; prio toggles after every contested cycle.
  - Uncontested cycles grant the sole requester and leave prio unchanged.
- Ready: in_ready = !full && !(rd_req && prio==0). It is combinational on out_ready and never depends on in_valid.
- Write grant:
  - mem_addr = wr_ptr, mem_wdata = in_data, mem_wen = 1.
  - At the edge: wr_ptr+1, mem_count+1.
- Read grant:
  - mem_addr = rd_ptr, mem_wen = 0.
  - At the edge: out_data <= mem_rdata, out_valid <= 1, rd_ptr+1, mem_count-1.
- Idle cycle: mem_addr = rd_ptr, mem_wen = 0.
- Pop without refill: out_valid && out_ready with no read grant gives out_valid <= 0.
- Latency without bypass, for an empty FIFO: word accepted at edge E is written at E, read in cycle E..E+1, and out_valid rises after edge E+1.
- Capacity and boundaries:
  - Capacity is DEPTH+1 words (memory plus output register).
  - full blocks pushes; in_ready stays 0 while full.
  - mem_count never under- or overflows.
- Reset mid-operation: all state returns to reset values immediately (async). In-flight words are discarded and out_valid drops without a handshake.

Optional Feature:
- FIFO_BYPASS_EN defined:
  - Condition: mem_count==0, wr_req, and the output register is empty or being consumed this cycle.
  - Then in_data loads straight into out_data/out_valid at the accepting edge, so out_valid is high after edge E.
  - No memory write occurs, mem_wen=0, and the port stays free.
- FIFO_BYPASS_EN undefined: every word passes through reg_mem with the latency above.

Decomposition:
- Shared include/package holds:
  - PRIO_RD=1'b0 and PRIO_WR=1'b1.
  - The DEPTH derivation macro.
  - Default DATA_WIDTH/ADDR_BITS, shared with reg_mem.
- One natural sub-module: fifo_ptr, a wrapping ADDR_BITS pointer with increment enable and async active-low clear. It is instantiated twice, for wr_ptr and rd_ptr.
- Top-level bench instantiates reg_mem_fifo_ctrl wired to reg_mem #(DATA_WIDTH,ADDR_BITS).

Test Plan:
- Reset then idle -> level=0, empty=1, out_valid=0, mem_wen=0; assert rst_n mid-stream -> all state cleared on the next sample.
- out_ready=0, push 1..9 back-to-back with in_valid held high:
  - After the first write, the contested cycle goes to the read, which loads 1 into the output register.
  - Values 2..9 fill the memory.
  - Final state: level=9, full=1, in_ready=0, out_data=1.
- Drain, continuing from the full state above with out_ready=1 and in_valid=0 -> out_data sequence 1..9 in order, one word per cycle after the first; end with empty=1, level=0.
- Pointer wrap: push 6, pop 6, then push 1..8 and pop all -> order preserved across address 7->0.
- Contention, with mem_count>0, out_valid=1, out_ready=1 and in_valid high every cycle -> grants alternate read/write and prio toggles each contested cycle; no push or pop is lost.
- FIFO_BYPASS_EN: push 5 into an empty FIFO with out_ready=0 -> out_valid=1, out_data=5 one edge later, mem_wen never asserted. Without the macro, out_valid rises one edge later than with it.
